data_mem_port: RTL and testbench
================================

Name: data_mem_port

Overview:
- Responder side of the CPU data-memory interface: word-addressed data RAM serving the CPU's MEM-stage load/store traffic.
- Handles byte-lane selection, alignment of store data into lanes, and extraction plus sign/zero extension of load data.
- Contains a post-reset clear engine, a registered debug read port for the display path, and a store counter.
- Sits between the CPU's ram_* outputs and its ram_data_out input at top level.

Parameters:
- ADDR_BITS, 12, byte-address width. The word address is ADDR_BITS-2 bits wide. DEPTH = 2^(ADDR_BITS-2) words (1024 by default).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ram_addr  input  ADDR_BITS-2  word address from the CPU.
- ram_data_in  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- ram_sel  input  4  byte-lane select.
- ram_rw  input  1  1 = store, 0 = load.
- ram_extend_type  input  1  load extension: 1 = sign, 0 = zero.
- ram_data_out  output  32  load data, right-aligned and extended; combinational.
- dbg_addr  input  ADDR_BITS-2  debug/display word address.
- dbg_data  output  32  registered raw word at dbg_addr.
- busy  output  1  high while the clear engine runs.
- store_count  output  32  number of accepted stores.

Behaviour:
- Lane map for ram_sel:
  - 1111: word.
  - 0011 / 1100: halfword in [15:0] / [31:16].
  - 0001 / 0010 / 0100 / 1000: byte in [7:0] / [15:8] / [23:16] / [31:24].
  - Any other nonzero pattern is "raw": no shifting, no extension.
- Load (combinational, zero latency):
  - Output is mem[ram_addr] with the selected lane(s) shifted down to bit 0.
  - Upper bits are filled by the lane's MSB if ram_extend_type=1, else zeros.
  - sel 1111 or raw: full word unmodified. sel 0000: output 0.
  - While busy=1, ram_data_out=0.
- Store (rising edge, when ram_rw=1 and busy=0):
  - The right-aligned ram_data_in is shifted into the selected lane(s). Only those lanes are written; other lanes hold.
  - Raw patterns write lane i from ram_data_in lane i.
  - sel 0000: no write and no count.
  - ram_extend_type is ignored on stores.
- Same-address store then load: the load in the same cycle sees the old data; the next cycle sees the new data.
- Clear engine, states IDLE and CLEAR:
  - rst=1 → CLEAR with clr_ptr=0 and busy=1, regardless of the current state (reset mid-clear restarts from 0).
  - In CLEAR, each cycle writes 0 to mem[clr_ptr] and increments clr_ptr.
  - When clr_ptr=DEPTH-1 is written → IDLE, busy=0.
  - A full clear occupies DEPTH cycles after rst deasserts; busy falls on the edge after the last word is written.
  - CPU stores during CLEAR are dropped and not counted.
- Debug port:
  - dbg_data <= mem[dbg_addr] on every edge (1-cycle latency).
  - If a store targets dbg_addr on the same edge, dbg_data captures the pre-store word.
  - Reset value 0. During CLEAR it still reads the array, so cleared words read 0.
- store_count:
  - Reset 0; +1 per accepted store; wraps from 0xFFFFFFFF to 0.
- Reset values: busy=1, store_count=0, dbg_data=0, ram_data_out=0 while busy.
- RAM contents are undefined until the clear engine completes.

Test Plan:
- Clear and busy: assert rst 1 cycle, deassert → busy=1 for exactly 1024 cycles then 0. dbg_addr=5 reads 0; a store issued mid-clear is dropped and store_count stays 0.
- Word store/load: store 0x8765_4321 at addr 3 with sel 1111 → next cycle a load of addr 3 returns 0x8765_4321; store_count=1.
- Byte lanes and extension:
  - Store 0x0000_00F0 at addr 7 with sel 0100 → word reads 0x00F0_0000.
  - Load sel 0100 with extend=1 → 0xFFFF_FFF0; with extend=0 → 0x0000_00F0.
- Halfword: word=0x8001_1234 (addr 9).
  - Load sel 1100, extend=1 → 0xFFFF_8001; sel 0011, extend=1 → 0x0000_1234.
  - Store 0x0000_ABCD with sel 1100 → word becomes 0xABCD_1234.
- Debug collision: dbg_addr=3 while storing 0x1111_1111 to addr 3 → dbg_data shows the old 0x8765_4321, then 0x1111_1111 on the next cycle.
- Reset mid-clear: assert rst at clear cycle 500 → busy stays high, the clear restarts at 0 and finishes 1024 cycles after the second rst deasserts; store_count=0.

Source files
------------

// File: rtl/data_mem_port.sv
// data_mem_port: word RAM for CPU loads/stores with lane alignment, post-reset clear, debug read port and store counter
module data_mem_port #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-3:0] ram_addr,
    input  logic [31:0]          ram_data_in,
    input  logic [3:0]           ram_sel,
    input  logic                 ram_rw,
    input  logic                 ram_extend_type,
    output logic [31:0]          ram_data_out,
    input  logic [ADDR_BITS-3:0] dbg_addr,
    output logic [31:0]          dbg_data,
    output logic                 busy,
    output logic [31:0]          store_count
);
    localparam int AW    = ADDR_BITS - 2;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic [31:0]     dbg_data_q, dbg_data_d;
    logic [31:0]     store_count_q, store_count_d;
    logic [31:0]     mem [DEPTH];
    logic [31:0]     rd_word, shifted, bit_mask, wr_data;
    logic [AW-1:0]   wr_addr;
    logic [4:0]      lane_shift;
    logic            is_half, is_byte, store_en, wr_en;

    assign busy         = (state_q == CLEAR);
    assign dbg_data     = dbg_data_q;
    assign store_count  = store_count_q;
    assign rd_word      = mem[ram_addr];
    assign bit_mask     = {{8{ram_sel[3]}}, {8{ram_sel[2]}}, {8{ram_sel[1]}}, {8{ram_sel[0]}}};
    assign shifted      = rd_word >> lane_shift;
    assign store_en     = !rst && !busy && ram_rw && (ram_sel != 4'b0000);

    // Aligned halfword/byte patterns move data between bit 0 and their lane; anything else is used raw
    always_comb begin
        lane_shift = 5'd0;
        is_half    = 1'b0;
        is_byte    = 1'b0;
        case (ram_sel)
            4'b0011: is_half = 1'b1;
            4'b1100: begin is_half = 1'b1; lane_shift = 5'd16; end
            4'b0001: is_byte = 1'b1;
            4'b0010: begin is_byte = 1'b1; lane_shift = 5'd8; end
            4'b0100: begin is_byte = 1'b1; lane_shift = 5'd16; end
            4'b1000: begin is_byte = 1'b1; lane_shift = 5'd24; end
            default: ;
        endcase
    end

    assign ram_data_out = (busy || ram_sel == 4'b0000) ? 32'd0 :
                          is_half ? {{16{ram_extend_type & shifted[15]}}, shifted[15:0]} :
                          is_byte ? {{24{ram_extend_type & shifted[7]}}, shifted[7:0]} :
                          rd_word;

    // The clear engine owns the single write port while busy
    assign wr_en   = !rst && (busy || store_en);
    assign wr_addr = busy ? clr_ptr_q : ram_addr;
    assign wr_data = busy ? 32'd0 : (rd_word & ~bit_mask) | ((ram_data_in << lane_shift) & bit_mask);

    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        dbg_data_d    = mem[dbg_addr];
        store_count_d = store_count_q + (store_en ? 32'd1 : 32'd0);
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            state_d   = (&clr_ptr_q) ? IDLE : CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= CLEAR;
            clr_ptr_q     <= '0;
            dbg_data_q    <= 32'd0;
            store_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            dbg_data_q    <= dbg_data_d;
            store_count_q <= store_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: random and directed checks of data_mem_port against a lane-level reference model
module tb_data_mem_port;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  ram_addr = '0;
    logic [31:0] ram_data_in = '0;
    logic [3:0]  ram_sel = '0;
    logic        ram_rw = 1'b0;
    logic        ram_extend_type = 1'b0;
    logic [31:0] ram_data_out;
    logic [9:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic        busy;
    logic [31:0] store_count;

    data_mem_port #(.ADDR_BITS(12)) dut (
        .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_sel(ram_sel), .ram_rw(ram_rw), .ram_extend_type(ram_extend_type),
        .ram_data_out(ram_data_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy(busy), .store_count(store_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          known [DEPTH];
    bit          m_busy = 1'b1;
    int          m_ptr = 0;
    logic [31:0] m_cnt = '0;
    logic [31:0] m_dbg = '0;
    bit          m_dbg_known = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit aligned(input logic [3:0] s);
        return s inside {4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    endfunction

    function automatic int low_lane(input logic [3:0] s);
        for (int i = 3; i >= 0; i--) if (s[i]) low_lane = i;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [3:0] s, input logic e);
        int off, nb;
        logic [31:0] v, m;
        if (s == 4'b0000) return 32'd0;
        if (!aligned(s)) return w;
        off = low_lane(s);
        nb  = $countones(s);
        m   = (nb == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
        v   = (w >> (8 * off)) & m;
        if (e && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    // Lane i takes din byte (i - first lane) for aligned patterns, din byte i otherwise
    function automatic logic [31:0] exp_store(input logic [31:0] w, input logic [3:0] s, input logic [31:0] d);
        int off;
        logic [31:0] r;
        off = aligned(s) ? low_lane(s) : 0;
        r = w;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*(i-off) +: 8];
        return r;
    endfunction

    task automatic step(input logic r, input logic rw, input logic [3:0] s, input logic [9:0] a,
                        input logic [31:0] d, input logic e, input logic [9:0] da);
        rst = r; ram_rw = rw; ram_sel = s; ram_addr = a; ram_data_in = d;
        ram_extend_type = e; dbg_addr = da;
        #1;
        if (!r) begin
            if (m_busy) check("ld_busy", ram_data_out, 32'd0);
            else if (known[a]) check("ld", ram_data_out, exp_load(ref_mem[a], s, e));
        end
        if (r) begin
            m_busy = 1'b1; m_ptr = 0; m_cnt = '0; m_dbg = '0; m_dbg_known = 1'b1;
            for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        end else begin
            m_dbg = ref_mem[da];
            m_dbg_known = known[da];
            if (m_busy) begin
                ref_mem[m_ptr] = '0;
                known[m_ptr] = 1'b1;
                if (m_ptr == DEPTH - 1) m_busy = 1'b0;
                m_ptr++;
            end else if (rw && s != 4'b0000) begin
                ref_mem[a] = exp_store(ref_mem[a], s, d);
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("count", store_count, m_cnt);
        if (m_dbg_known) check("dbg", dbg_data, m_dbg);
    endtask

    task automatic idle(input logic [9:0] da);
        step(1'b0, 1'b0, 4'b0000, 10'd0, 32'd0, 1'b0, da);
    endtask

    task automatic peek(input string tag, input logic [9:0] a, input logic [3:0] s, input logic e,
                        input logic [31:0] exp);
        ram_rw = 1'b0; ram_addr = a; ram_sel = s; ram_extend_type = e;
        #1;
        check(tag, ram_data_out, exp);
    endtask

    int n;
    logic [3:0] sel_tab [10] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010,
                                 4'b0100, 4'b1000, 4'b0000, 4'b0101, 4'b1110};

    initial begin
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; known[i] = 1'b0; end
        step(1'b1, 1'b0, 4'b0000, 10'd0, 32'd0, 1'b0, 10'd5);
        check("rst_dbg", dbg_data, 32'd0);
        n = 0;
        while (busy && n < 2000) begin
            if (n == 300) step(1'b0, 1'b1, 4'b1111, 10'd3, 32'hDEAD_BEEF, 1'b0, 10'd5);
            else idle(10'd5);
            n++;
        end
        check("clear_len", n, 1024);
        check("dbg5_zero", dbg_data, 32'd0);
        check("drop_cnt", store_count, 32'd0);

        step(1'b0, 1'b1, 4'b1111, 10'd3, 32'h8765_4321, 1'b0, 10'd0);
        peek("word_ld", 10'd3, 4'b1111, 1'b0, 32'h8765_4321);
        check("word_cnt", store_count, 32'd1);

        step(1'b0, 1'b1, 4'b0100, 10'd7, 32'h0000_00F0, 1'b1, 10'd0);
        peek("byte_word", 10'd7, 4'b1111, 1'b0, 32'h00F0_0000);
        peek("byte_sx", 10'd7, 4'b0100, 1'b1, 32'hFFFF_FFF0);
        peek("byte_zx", 10'd7, 4'b0100, 1'b0, 32'h0000_00F0);

        step(1'b0, 1'b1, 4'b1111, 10'd9, 32'h8001_1234, 1'b0, 10'd0);
        peek("half_hi_sx", 10'd9, 4'b1100, 1'b1, 32'hFFFF_8001);
        peek("half_lo_sx", 10'd9, 4'b0011, 1'b1, 32'h0000_1234);
        step(1'b0, 1'b1, 4'b1100, 10'd9, 32'h0000_ABCD, 1'b0, 10'd0);
        peek("half_st", 10'd9, 4'b1111, 1'b0, 32'hABCD_1234);
        peek("sel0_ld", 10'd9, 4'b0000, 1'b1, 32'd0);

        step(1'b0, 1'b1, 4'b1111, 10'd3, 32'h1111_1111, 1'b0, 10'd3);
        check("dbg_old", dbg_data, 32'h8765_4321);
        idle(10'd3);
        check("dbg_new", dbg_data, 32'h1111_1111);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] s;
            int k;
            k = $urandom_range(0, 11);
            s = (k < 10) ? sel_tab[k] : 4'($urandom);
            step(1'b0, 1'($urandom), s, 10'($urandom_range(0, 15)), $urandom,
                 1'($urandom), 10'($urandom_range(0, 15)));
        end

        step(1'b1, 1'b0, 4'b0000, 10'd0, 32'd0, 1'b0, 10'd0);
        for (int i = 0; i < 500; i++) idle(10'd0);
        step(1'b1, 1'b0, 4'b0000, 10'd0, 32'd0, 1'b0, 10'd0);
        n = 0;
        while (busy && n < 2000) begin
            idle(10'($urandom_range(0, 15)));
            n++;
        end
        check("reclear_len", n, 1024);
        check("reclear_cnt", store_count, 32'd0);
        peek("reclear_ld", 10'd3, 4'b1111, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
